// File: rtl/led_pattern_gen.sv
// Animated LED pattern driver (static, blink, binary count, bouncing scan) stepped by a prescaler.
// Optional PWM dimming is enabled by defining LED_PWM_EN.
module led_pattern_gen #(
    parameter int NLEDS    = 8,
    parameter int CLK_HZ   = 12_000_000,
    parameter int STEP_HZ  = 10,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [NLEDS-1:0]    leds,
    output logic                step
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {ALL_ON = 2'b00, BLINK = 2'b01, COUNT = 2'b10, SCAN = 2'b11} mode_t;
    typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} dir_t;

    logic [PW-1:0]    presc;
    logic [NLEDS-1:0] pat, seed, shl, shr, en;
    mode_t            mode_q;
    dir_t             dir;
    logic             init, tick, reload;

    assign tick   = (presc == LAST);
    // init forces a seed load on the first cycle after reset, even when mode matches mode_q
    assign reload = init | (mode_t'(mode) != mode_q);
    assign shl    = pat << 1;
    assign shr    = pat >> 1;

    always_comb begin
        seed = '1;
        case (mode_t'(mode))
            COUNT:   seed = '0;
            SCAN:    seed = NLEDS'(1);
            default: seed = '1;
        endcase
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    // full-scale brightness must be steady on, which pwm_cnt < brightness alone cannot give
    assign en = (&brightness) ? '1 : {NLEDS{pwm_cnt < brightness}};
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign en = '1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc  <= '0;
            pat    <= '0;
            dir    <= LEFT;
            mode_q <= ALL_ON;
            init   <= 1'b1;
            step   <= 1'b0;
        end else begin
            mode_q <= mode_t'(mode);
            init   <= 1'b0;
            if (reload) begin
                presc <= '0;
                pat   <= seed;
                dir   <= LEFT;
                step  <= 1'b0;
            end else begin
                step  <= tick;
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    case (mode_q)
                        BLINK: pat <= ~pat;
                        COUNT: pat <= pat + NLEDS'(1);
                        SCAN: begin
                            if (dir == LEFT) begin
                                pat <= shl;
                                if (shl[NLEDS-1]) dir <= RIGHT;
                            end else begin
                                pat <= shr;
                                if (shr[0]) dir <= LEFT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) leds <= '0;
        else       leds <= pat & en;
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen with NLEDS=4, DIV=8, PWM_BITS=2.
module tb_led_pattern_gen;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] brightness = 2'd3;
    logic [3:0] leds;
    logic       step;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [3:0] exp_q[$];

    led_pattern_gen #(.NLEDS(4), .CLK_HZ(8), .STEP_HZ(1), .PWM_BITS(2)) dut (
        .clk(clk), .rstn(rstn), .mode(mode), .brightness(brightness), .leds(leds), .step(step)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic clkn(input int n);
        repeat (n) clk1();
    endtask

    task automatic wait_step(input string name, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < 40) begin
            clk1();
            n++;
            if (step === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s step_timeout: got no pulse want pulse", name);
        end
    endtask

    // pops one expected LED value per observed step; leds lag pat by one clock
    task automatic drain(input string name, input int first_gap, input int ref_cyc, input bit onehot);
        int prev, gap, want_gap, k;
        bit ok;
        logic [3:0] e;
        prev = ref_cyc;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_step(name, ok);
            if (!ok) begin
                exp_q.delete();
                return;
            end
            gap = cyc - prev;
            prev = cyc;
            want_gap = (k == 0) ? first_gap : 8;
            total++;
            if (gap !== want_gap) begin
                bad++;
                $display("FAIL %s gap[%0d]: got %0d want %0d", name, k, gap, want_gap);
            end
            clk1();
            total++;
            if (leds !== e) begin
                bad++;
                $display("FAIL %s leds[%0d]: got %b want %b", name, k, leds, e);
            end
            if (onehot) begin
                total++;
                if ($countones(leds) != 1) begin
                    bad++;
                    $display("FAIL %s onehot[%0d]: got %b want one bit", name, k, leds);
                end
            end
            k++;
        end
    endtask

    task automatic test_reset();
        int r;
        rstn = 1'b0;
        mode = 2'b00;
        clkn(3);
        total++;
        if (leds !== 4'b0000) begin bad++; $display("FAIL reset_leds: got %b want 0000", leds); end
        total++;
        if (step !== 1'b0) begin bad++; $display("FAIL reset_step: got %b want 0", step); end
        rstn = 1'b1;
        r = cyc;
        clkn(2);
        total++;
        if (leds !== 4'b1111) begin bad++; $display("FAIL all_on_init: got %b want 1111", leds); end
        repeat (3) exp_q.push_back(4'b1111);
        drain("all_on", 9, r, 1'b0);
    endtask

    task automatic test_count();
        int r;
        mode = 2'b10;
        r = cyc;
        clkn(2);
        total++;
        if (leds !== 4'b0000) begin bad++; $display("FAIL count_seed: got %b want 0000", leds); end
        for (int i = 1; i <= 16; i++) exp_q.push_back(4'(i));
        drain("count", 9, r, 1'b0);
    endtask

    task automatic test_scan();
        int r;
        logic [3:0] seq [7];
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        mode = 2'b11;
        r = cyc;
        clkn(2);
        total++;
        if (leds !== 4'b0001) begin bad++; $display("FAIL scan_seed: got %b want 0001", leds); end
        for (int i = 0; i < 7; i++) exp_q.push_back(seq[i]);
        drain("scan", 9, r, 1'b1);
    endtask

    task automatic test_change_on_tick();
        int r;
        bit ok;
        mode = 2'b10;
        clkn(2);
        wait_step("align", ok);
        clkn(7);
        mode = 2'b01;
        r = cyc;
        clk1();
        total++;
        if (step !== 1'b0) begin bad++; $display("FAIL tick_suppressed: got %b want 0", step); end
        clk1();
        total++;
        if (leds !== 4'b1111) begin bad++; $display("FAIL blink_seed: got %b want 1111", leds); end
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b1111);
        drain("blink", 9, r, 1'b0);
    endtask

    task automatic test_reset_mid_scan();
        int r;
        mode = 2'b11;
        r = cyc;
        clkn(2);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        drain("scan_pre", 9, r, 1'b1);
        rstn = 1'b0;
        #1;
        total++;
        if (leds !== 4'b0000) begin bad++; $display("FAIL async_reset_leds: got %b want 0000", leds); end
        clkn(2);
        rstn = 1'b1;
        r = cyc;
        clkn(2);
        total++;
        if (leds !== 4'b0001) begin bad++; $display("FAIL scan_restart: got %b want 0001", leds); end
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0100);
        drain("scan_post", 9, r, 1'b1);
    endtask

    task automatic test_pwm();
        int lit, dark, want;
        logic [1:0] blist [4];
        blist = '{2'd1, 2'd3, 2'd0, 2'd2};
        mode = 2'b00;
        clkn(4);
        for (int i = 0; i < 4; i++) begin
            brightness = blist[i];
            clkn(3);
            lit = 0;
            dark = 0;
            for (int c = 0; c < 8; c++) begin
                clk1();
                if (leds === 4'b1111) lit++;
                else if (leds === 4'b0000) dark++;
            end
`ifdef LED_PWM_EN
            want = (blist[i] == 2'd3) ? 8 : 2 * int'(blist[i]);
`else
            want = 8;
`endif
            total++;
            if (lit !== want) begin bad++; $display("FAIL pwm_lit b=%0d: got %0d want %0d", blist[i], lit, want); end
            total++;
            if (lit + dark !== 8) begin bad++; $display("FAIL pwm_levels b=%0d: got %0d want 8", blist[i], lit + dark); end
        end
        brightness = 2'd3;
    endtask

    initial begin
        test_reset();
        test_count();
        test_scan();
        test_change_on_tick();
        test_reset_mid_scan();
        test_pwm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
